// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller and the coin payout path:
// coin values, one-hot coin encodings and the dispenser state encoding.
package vending_pkg;

    localparam logic [5:0] COIN_10 = 6'd10;
    localparam logic [5:0] COIN_5  = 6'd5;
    localparam logic [5:0] COIN_1  = 6'd1;

    localparam logic [2:0] OH_10 = 3'b100;
    localparam logic [2:0] OH_5  = 3'b010;
    localparam logic [2:0] OH_1  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } disp_state_e;

    function automatic logic [5:0] coin_value(input logic [2:0] oh);
        case (oh)
            OH_10:   coin_value = COIN_10;
            OH_5:    coin_value = COIN_5;
            OH_1:    coin_value = COIN_1;
            default: coin_value = 6'd0;
        endcase
    endfunction

    function automatic logic is_onehot3(input logic [2:0] v);
        case (v)
            OH_10, OH_5, OH_1: is_onehot3 = 1'b1;
            default:           is_onehot3 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Stock counter for one coin denomination: saturating refill, single-coin
// decrement on ejection, registered count and nonzero flag.
module coin_inventory #(
    parameter int INV_W = 4,
    parameter int INIT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [INV_W-1:0] inc_cnt,
    input  logic             dec,
    output logic [INV_W-1:0] count,
    output logic             nonzero
);

    localparam logic [INV_W-1:0] MAX_CNT = {INV_W{1'b1}};
    localparam logic [INV_W-1:0] ONE     = {{(INV_W-1){1'b0}}, 1'b1};
    localparam logic [INV_W-1:0] ZERO    = {INV_W{1'b0}};

    logic [INV_W-1:0] count_q;
    logic             nonzero_q;
    logic [INV_W:0]   sum_s;
    logic [INV_W-1:0] sat_s;
    logic [INV_W-1:0] count_d;

    // Refill is applied (and clamped) before the ejection is taken off, so a
    // same-cycle refill and ejection yields sat(stock + cnt) - 1.
    always_comb begin
        if (inc) begin
            sum_s = {1'b0, count_q} + {1'b0, inc_cnt};
        end else begin
            sum_s = {1'b0, count_q};
        end
        if (sum_s[INV_W]) begin
            sat_s = MAX_CNT;
        end else begin
            sat_s = sum_s[INV_W-1:0];
        end
        if (dec && (sat_s != ZERO)) begin
            count_d = sat_s - ONE;
        end else begin
            count_d = sat_s;
        end
    end

    // Stock register and its nonzero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= INV_W'(INIT);
            nonzero_q <= (INIT != 0);
        end else begin
            count_q   <= count_d;
            nonzero_q <= (count_d != ZERO);
        end
    end

    assign count   = count_q;
    assign nonzero = nonzero_q;

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays out a change amount one coin at a time to a hopper, choosing the
// largest stocked coin that fits, and reports completion or shortfall.
module coin_change_dispenser
    import vending_pkg::*;
#(
    parameter int INV_W   = 4,
    parameter int INIT_10 = 4,
    parameter int INIT_5  = 4,
    parameter int INIT_1  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_valid,
    input  logic [5:0]       change,
    output logic             busy,
    output logic             coin_valid,
    output logic [2:0]       coin_out,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [5:0]       remaining,
    input  logic             refill,
    input  logic [2:0]       refill_sel,
    input  logic [INV_W-1:0] refill_cnt
);

    disp_state_e      state_q;
    logic             busy_q;
    logic             coin_valid_q;
    logic [2:0]       coin_q;
    logic             done_q;
    logic             short_q;
    logic [5:0]       remaining_q;

    logic [2:0]       inc_s;
    logic [2:0]       dec_s;
    logic [2:0]       pick_s;
    logic [2:0]       nz_s;
    logic             ack_ok_s;
    logic [INV_W-1:0] cnt_10_s;
    logic [INV_W-1:0] cnt_5_s;
    logic [INV_W-1:0] cnt_1_s;

    // Refill decode, ejection decrement and greedy coin selection
    always_comb begin
        if (refill && is_onehot3(refill_sel)) begin
            inc_s = refill_sel;
        end else begin
            inc_s = 3'b000;
        end
        // Ack is only honoured for a denomination that actually has stock.
        ack_ok_s = |(coin_q & nz_s);
        if ((state_q == ST_ISSUE) && coin_ack && ack_ok_s) begin
            dec_s = coin_q;
        end else begin
            dec_s = 3'b000;
        end
        if ((remaining_q >= COIN_10) && (cnt_10_s != {INV_W{1'b0}})) begin
            pick_s = OH_10;
        end else if ((remaining_q >= COIN_5) && (cnt_5_s != {INV_W{1'b0}})) begin
            pick_s = OH_5;
        end else if ((remaining_q >= COIN_1) && (cnt_1_s != {INV_W{1'b0}})) begin
            pick_s = OH_1;
        end else begin
            pick_s = 3'b000;
        end
    end

    coin_inventory #(.INV_W(INV_W), .INIT(INIT_10)) u_inv_10 (
        .clk(clk), .rst(rst), .inc(inc_s[2]), .inc_cnt(refill_cnt),
        .dec(dec_s[2]), .count(cnt_10_s), .nonzero(nz_s[2])
    );

    coin_inventory #(.INV_W(INV_W), .INIT(INIT_5)) u_inv_5 (
        .clk(clk), .rst(rst), .inc(inc_s[1]), .inc_cnt(refill_cnt),
        .dec(dec_s[1]), .count(cnt_5_s), .nonzero(nz_s[1])
    );

    coin_inventory #(.INV_W(INV_W), .INIT(INIT_1)) u_inv_1 (
        .clk(clk), .rst(rst), .inc(inc_s[0]), .inc_cnt(refill_cnt),
        .dec(dec_s[0]), .count(cnt_1_s), .nonzero(nz_s[0])
    );

    // Payout FSM with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            coin_valid_q <= 1'b0;
            coin_q       <= 3'b000;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            remaining_q  <= 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    if (change_valid) begin
                        remaining_q <= change;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining_q == 6'd0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        short_q <= 1'b0;
                    end else if (pick_s != 3'b000) begin
                        coin_q       <= pick_s;
                        coin_valid_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end else begin
                        state_q <= ST_FAULT;
                        done_q  <= 1'b1;
                        short_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (coin_ack) begin
                        coin_valid_q <= 1'b0;
                        coin_q       <= 3'b000;
                        if (ack_ok_s) begin
                            remaining_q <= remaining_q - coin_value(coin_q);
                            state_q     <= ST_SELECT;
                        end else begin
                            state_q <= ST_FAULT;
                            done_q  <= 1'b1;
                            short_q <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_FAULT: begin
                    done_q  <= 1'b0;
                    short_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    coin_valid_q <= 1'b0;
                    coin_q       <= 3'b000;
                    done_q       <= 1'b0;
                    short_q      <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign coin_valid = coin_valid_q;
    assign coin_out   = coin_q;
    assign done       = done_q;
    assign short      = short_q;
    assign remaining  = remaining_q;

endmodule
